program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//   Writer side of the fetch-module instruction-memory write port. Receives a byte
//   stream (e.g. from a UART RX), assembles 16-bit instruction words and drives
//   write_enable_fm/write_data_fm/write_addr_fm. Holds the core in reset until the
//   image has been written, then releases it. Sits between the host link and
//   pipelinedProcessor.
// PARAMETERS
//   ADDR_W     32    width of write_addr_fm
//   BASE_ADDR  0     instruction-memory address of the first word
//   MAX_WORDS  1024  largest accepted word count; a larger header is an error
// PORTS
//   clk            in   1       single clock, rising edge
//   reset          in   1       synchronous, active-high
//   byte_valid     in   1       byte_data is valid
//   byte_data      in   8       incoming stream byte
//   byte_ready     out  1       loader accepts byte; transfer = byte_valid & byte_ready
//   restart        in   1       one-cycle pulse: begin a new load from DONE or ERROR
//   write_enable_fm out 1       one-cycle write strobe to fetch memory
//   write_data_fm  out  16      instruction word
//   write_addr_fm  out  ADDR_W  word address = BASE_ADDR + index
//   cpu_reset      out  1       drives processor reset/rst_fm; high while loading
//   load_done      out  1       image written, core released
//   load_error     out  1       bad header (or checksum) detected
// BEHAVIOUR
//   - Frame format: CNT_LO, CNT_HI (16-bit word count N, little-endian), then N words
//     as LO byte then HI byte; then CHK byte when LOADER_CHECKSUM_EN is defined.
//   - States: HDR_LO, HDR_HI, DAT_LO, DAT_HI, WRITE, [CHK], DONE, ERROR.
//   - Reset: state=HDR_LO, write_enable_fm=0, write_data_fm=0, write_addr_fm=BASE_ADDR,
//     cpu_reset=1, load_done=0, load_error=0, word index=0. All outputs registered.
//   - byte_ready = 1 in HDR_LO/HDR_HI/DAT_LO/DAT_HI/CHK; 0 in WRITE/DONE/ERROR and
//     while reset is high. States advance only on an accepted byte; byte_valid
//     without byte_ready is ignored (no buffering).
//   - HDR_HI accept: N==0 -> DONE (or CHK); N>MAX_WORDS -> ERROR; else DAT_LO.
//   - DAT_HI accept -> WRITE. In the next cycle write_enable_fm=1 for exactly one
//     cycle, with data={HI,LO} and addr=BASE_ADDR+index. Index increments; the FSM
//     returns to DAT_LO, or on the last word goes to DONE (or CHK). Minimum 3 cycles
//     per word.
//   - DONE: cpu_reset=0 and load_done=1 from the cycle after the final write strobe
//     (or after the CHK accept). They stay at these values until restart or reset.
//   - ERROR: cpu_reset stays 1, load_error=1; no further writes.
//   - restart is honoured only in DONE/ERROR. Next cycle: state=HDR_LO, cpu_reset=1,
//     load_done=0, load_error=0, index=0. restart in any other state is ignored.
//   - Reset mid-load aborts immediately. No strobe is issued for a partial word, and
//     already-written words are not cleared.
//   - Address arithmetic is modulo 2^ADDR_W. Index width is clog2(MAX_WORDS+1).
// CONFIGURATION
//   LOADER_CHECKSUM_EN defined: after the last word (or after a header with N==0)
//     the FSM enters CHK and accepts one byte. It compares that byte with the XOR of
//     all prior frame bytes, including the header. Match -> DONE; mismatch -> ERROR.
//     Words already written are not rolled back.
//   Not defined: no CHK state, no XOR register; the last write goes straight to DONE.
// TESTING
//   1. Reset; stream 02 00 34 12 CD AB -> strobes 0x1234@0 and 0xABCD@1; then
//      cpu_reset=0 and load_done=1 one cycle after the second strobe.
//   2. Header 00 00 -> no strobes; load_done=1 (with CHK byte 00 when checksum on).
//   3. Header 01 04 with MAX_WORDS=1024 (N=1025) -> load_error=1, cpu_reset=1, no
//      strobes, byte_ready=0.
//   4. byte_valid held high continuously -> byte_ready drops in WRITE; each word is
//      written exactly once; no bytes are lost or duplicated.
//   5. Assert reset after 01 00 78 -> no strobe; the next frame 01 00 EF BE writes
//      0xBEEF@BASE_ADDR.
//   6. LOADER_CHECKSUM_EN: 01 00 11 22 32 -> DONE; 01 00 11 22 00 -> ERROR. A
//      restart pulse from ERROR returns to HDR_LO with cpu_reset=1.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: writer side of the fetch-module instruction-memory port.
// Parses a byte stream (count header, then little-endian 16-bit words), issues one
// write strobe per word and holds the core in reset until the image is complete.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module program_loader #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              restart,
  output logic              write_enable_fm,
  output logic [15:0]       write_data_fm,
  output logic [ADDR_W-1:0] write_addr_fm,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error
);

  localparam int unsigned IDX_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    ST_HDR_LO = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_DAT_LO = 3'd2,
    ST_DAT_HI = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
`ifdef LOADER_CHECKSUM_EN
    , ST_CHK  = 3'd7
`endif
  } state_e;

  // States in which the loader is willing to take a byte from the link.
  function automatic logic accepts_byte(input state_e st);
    logic acc;
    case (st)
      ST_HDR_LO, ST_HDR_HI, ST_DAT_LO, ST_DAT_HI: acc = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      ST_CHK:                                     acc = 1'b1;
`endif
      default:                                    acc = 1'b0;
    endcase
    return acc;
  endfunction

`ifdef LOADER_CHECKSUM_EN
  // Running checksum: plain XOR of every frame byte seen so far.
  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  state_e              state_q, state_d;
  logic [7:0]          cnt_lo_q, cnt_lo_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [7:0]          lo_q, lo_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                we_q, we_d;
  logic [15:0]         data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                byte_ready_q, byte_ready_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          chk_q, chk_d;
`endif

  logic                xfer_s;
  logic [15:0]         hdr_cnt_s;
  logic                hdr_too_big_s;
  logic                last_word_s;

  // The ready flop tracks the state; reset forces the handshake low immediately.
  assign byte_ready      = byte_ready_q & ~reset;
  assign xfer_s          = byte_valid & byte_ready;
  assign hdr_cnt_s       = {byte_data, cnt_lo_q};
  assign hdr_too_big_s   = ({16'd0, hdr_cnt_s} > 32'(MAX_WORDS));
  assign last_word_s     = ((32'(idx_q) + 32'd1) == {16'd0, cnt_q});

  assign write_enable_fm = we_q;
  assign write_data_fm   = data_q;
  assign write_addr_fm   = addr_q;
  assign cpu_reset       = cpu_reset_q;
  assign load_done       = done_q;
  assign load_error      = err_q;

  // Next-state and next-output computation for the frame parser.
  always_comb begin
    state_d     = state_q;
    cnt_lo_d    = cnt_lo_q;
    cnt_d       = cnt_q;
    lo_d        = lo_q;
    idx_d       = idx_q;
    we_d        = 1'b0;
    data_d      = data_q;
    addr_d      = addr_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    err_d       = err_q;
`ifdef LOADER_CHECKSUM_EN
    chk_d       = chk_q;
    if (xfer_s) begin
      chk_d = chk_update(chk_q, byte_data);
    end else begin
      chk_d = chk_q;
    end
`endif

    case (state_q)
      ST_HDR_LO: begin
        if (xfer_s) begin
          cnt_lo_d = byte_data;
          state_d  = ST_HDR_HI;
        end else begin
          state_d  = ST_HDR_LO;
        end
      end

      ST_HDR_HI: begin
        if (xfer_s) begin
          cnt_d = hdr_cnt_s;
          if (hdr_cnt_s == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d     = ST_CHK;
`else
            state_d     = ST_DONE;
            cpu_reset_d = 1'b0;
            done_d      = 1'b1;
`endif
          end else if (hdr_too_big_s) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else begin
            state_d = ST_DAT_LO;
          end
        end else begin
          state_d = ST_HDR_HI;
        end
      end

      ST_DAT_LO: begin
        if (xfer_s) begin
          lo_d    = byte_data;
          state_d = ST_DAT_HI;
        end else begin
          state_d = ST_DAT_LO;
        end
      end

      ST_DAT_HI: begin
        if (xfer_s) begin
          data_d  = {byte_data, lo_q};
          addr_d  = BASE_ADDR + ADDR_W'(idx_q);
          we_d    = 1'b1;
          state_d = ST_WRITE;
        end else begin
          state_d = ST_DAT_HI;
        end
      end

      // Strobe is visible in this cycle; advance the index and pick the next word.
      ST_WRITE: begin
        idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
        if (last_word_s) begin
`ifdef LOADER_CHECKSUM_EN
          state_d     = ST_CHK;
`else
          state_d     = ST_DONE;
          cpu_reset_d = 1'b0;
          done_d      = 1'b1;
`endif
        end else begin
          state_d = ST_DAT_LO;
        end
      end

`ifdef LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (xfer_s) begin
          if (byte_data == chk_q) begin
            state_d     = ST_DONE;
            cpu_reset_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end
        end else begin
          state_d = ST_CHK;
        end
      end
`endif

      ST_DONE, ST_ERROR: begin
        if (restart) begin
          state_d     = ST_HDR_LO;
          cpu_reset_d = 1'b1;
          done_d      = 1'b0;
          err_d       = 1'b0;
          idx_d       = '0;
`ifdef LOADER_CHECKSUM_EN
          chk_d       = 8'd0;
`endif
        end else begin
          state_d = state_q;
        end
      end

      // Unreachable encoding: park in ERROR with the core held in reset.
      default: begin
        state_d     = ST_ERROR;
        cpu_reset_d = 1'b1;
        done_d      = 1'b0;
        err_d       = 1'b1;
      end
    endcase

    byte_ready_d = accepts_byte(state_d);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_HDR_LO;
      cnt_lo_q     <= 8'd0;
      cnt_q        <= 16'd0;
      lo_q         <= 8'd0;
      idx_q        <= '0;
      we_q         <= 1'b0;
      data_q       <= 16'd0;
      addr_q       <= BASE_ADDR;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      byte_ready_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      chk_q        <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_lo_q     <= cnt_lo_d;
      cnt_q        <= cnt_d;
      lo_q         <= lo_d;
      idx_q        <= idx_d;
      we_q         <= we_d;
      data_q       <= data_d;
      addr_q       <= addr_d;
      cpu_reset_q  <= cpu_reset_d;
      done_q       <= done_d;
      err_q        <= err_d;
      byte_ready_q <= byte_ready_d;
`ifdef LOADER_CHECKSUM_EN
      chk_q        <= chk_d;
`endif
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table-driven frames, cycle-exact corner
// sequences and random frames checked against a frame-level reference model.
module tb_program_loader;

  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int          MAXW   = 1024;

  logic        clk = 1'b0;
  logic        reset, byte_valid, restart, byte_ready;
  logic [7:0]  byte_data;
  logic        write_enable_fm, cpu_reset, load_done, load_error;
  logic [15:0] write_data_fm;
  logic [31:0] write_addr_fm;

  program_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .restart(restart), .write_enable_fm(write_enable_fm),
    .write_data_fm(write_data_fm), .write_addr_fm(write_addr_fm),
    .cpu_reset(cpu_reset), .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [63:0] bytes;
    int          len;
    int          exp_writes;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  int         errors = 0;
  int         checks = 0;
  wr_t        wr_q[$];
  wr_t        exp_q[$];
  logic [7:0] tx_q[$];
  bit         exp_done, exp_err;
  vec_t       vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: records every strobe and checks the link is stalled meanwhile.
  always @(negedge clk) begin
    if (write_enable_fm === 1'b1) begin
      wr_q.push_back({write_addr_fm, write_data_fm});
      check("ready_low_in_write", 64'(byte_ready), 64'd0);
    end
  end

  // Reference model: interpret tx_q as a frame and list the writes and final status.
  function automatic void model();
    int         n;
    logic [7:0] x;
    exp_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    n = int'({tx_q[1], tx_q[0]});
    x = tx_q[0] ^ tx_q[1];
    if (n > MAXW) begin
      exp_err = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({BASE + 32'(i), tx_q[3 + 2*i], tx_q[2 + 2*i]});
      x = x ^ tx_q[2 + 2*i] ^ tx_q[3 + 2*i];
    end
`ifdef LOADER_CHECKSUM_EN
    if (tx_q[2 + 2*n] == x) exp_done = 1'b1;
    else                    exp_err  = 1'b1;
`else
    exp_done = 1'b1;
`endif
  endfunction

  // Append the correct checksum byte when the checksum feature is built in.
  function automatic void add_chk();
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x = 8'd0;
    foreach (tx_q[i]) x = x ^ tx_q[i];
    tx_q.push_back(x);
`endif
  endfunction

  function automatic void build_frame(input int n);
    tx_q.delete();
    tx_q.push_back(n[7:0]);
    tx_q.push_back(n[15:8]);
    if (n <= MAXW) begin
      for (int i = 0; i < 2*n; i++) tx_q.push_back(8'($urandom));
      add_chk();
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
      end
    end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      check("byte_accept_timeout", 64'(guard), 64'd0);
      byte_valid = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset      = 1'b1;
    byte_valid = 1'b0;
    restart    = 1'b0;
    repeat (2) @(negedge clk);
    check("ready_in_reset", 64'(byte_ready), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_we",    64'(write_enable_fm), 64'd0);
    check("rst_data",  64'(write_data_fm),   64'd0);
    check("rst_addr",  64'(write_addr_fm),   64'(BASE));
    check("rst_cpu",   64'(cpu_reset),       64'd1);
    check("rst_done",  64'(load_done),       64'd0);
    check("rst_err",   64'(load_error),      64'd0);
    check("rst_ready", 64'(byte_ready),      64'd1);
  endtask

  task automatic wait_end();
    int t = 0;
    @(negedge clk);
    byte_valid = 1'b0;
    while (!(load_done || load_error) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check("end_timeout", 64'(t), 64'd0);
  endtask

  task automatic compare_results(input string tag);
    check({tag, "_nwr"}, 64'(wr_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      check({tag, "_addr"}, 64'(wr_q[i].addr), 64'(exp_q[i].addr));
      check({tag, "_data"}, 64'(wr_q[i].data), 64'(exp_q[i].data));
    end
    check({tag, "_done"},  64'(load_done),  64'(exp_done));
    check({tag, "_err"},   64'(load_error), 64'(exp_err));
    check({tag, "_cpu"},   64'(cpu_reset),  64'(!exp_done));
    check({tag, "_ready"}, 64'(byte_ready), 64'd0);
  endtask

  task automatic end_frame();
    if (load_done || load_error) begin
      @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      check("restart_cpu",   64'(cpu_reset),  64'd1);
      check("restart_done",  64'(load_done),  64'd0);
      check("restart_err",   64'(load_error), 64'd0);
      check("restart_ready", 64'(byte_ready), 64'd1);
    end else begin
      apply_reset();
    end
  endtask

  task automatic run_frame(input string tag, input bit gaps);
    wr_q.delete();
    model();
    foreach (tx_q[i]) send_byte(tx_q[i], gaps);
    wait_end();
    compare_results(tag);
  endtask

  initial begin
    reset      = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    restart    = 1'b0;

    vecs[0] = '{64'h0000_ABCD_1234_0002, 6, 2, 1'b1, 1'b0};
    vecs[1] = '{64'h0000_0000_0000_0000, 2, 0, 1'b1, 1'b0};
    vecs[2] = '{64'h0000_0000_0000_0401, 2, 0, 1'b0, 1'b1};
    vecs[3] = '{64'h0000_0000_BEEF_0001, 4, 1, 1'b1, 1'b0};
    vecs[4] = '{64'h0000_0000_0000_FFFF, 2, 0, 1'b0, 1'b1};
    vecs[5] = '{64'hBC9A_7856_3412_0003, 8, 3, 1'b1, 1'b0};

    apply_reset();

    // Two-word frame with cycle-exact strobe and release timing.
    wr_q.delete();
    tx_q = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB};
    add_chk();
    model();
    for (int i = 0; i < 6; i++) send_byte(tx_q[i], 1'b0);
    @(negedge clk);
    byte_valid = 1'b0;
    check("t1_we",   64'(write_enable_fm), 64'd1);
    check("t1_addr", 64'(write_addr_fm),   64'd1);
    check("t1_data", 64'(write_data_fm),   64'hABCD);
    check("t1_done_early", 64'(load_done), 64'd0);
    check("t1_cpu_early",  64'(cpu_reset), 64'd1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(tx_q[6], 1'b0);
    @(negedge clk);
    byte_valid = 1'b0;
`else
    @(negedge clk);
`endif
    check("t1_we_off", 64'(write_enable_fm), 64'd0);
    check("t1_done",   64'(load_done),       64'd1);
    check("t1_cpu",    64'(cpu_reset),       64'd0);
    compare_results("t1");
    end_frame();

    // Table of whole frames, alternating idle gaps and continuous valid.
    for (int v = 0; v < 6; v++) begin
      tx_q.delete();
      for (int i = 0; i < vecs[v].len; i++) tx_q.push_back(vecs[v].bytes[8*i +: 8]);
      if (!vecs[v].exp_err) add_chk();
      run_frame("vec", v[0]);
      check("vec_nwr_tbl",  64'(wr_q.size()), 64'(vecs[v].exp_writes));
      check("vec_done_tbl", 64'(load_done),   64'(vecs[v].exp_done));
      check("vec_err_tbl",  64'(load_error),  64'(vecs[v].exp_err));
      end_frame();
    end

    // Reset in the middle of a word: no strobe, next frame loads normally.
    wr_q.delete();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h78, 1'b0);
    apply_reset();
    check("abort_no_strobe", 64'(wr_q.size()), 64'd0);
    tx_q = '{8'h01, 8'h00, 8'hEF, 8'hBE};
    add_chk();
    run_frame("after_abort", 1'b0);
    end_frame();

    // restart in a loading state must be ignored.
    wr_q.delete();
    tx_q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    add_chk();
    model();
    for (int i = 0; i < 3; i++) send_byte(tx_q[i], 1'b0);
    @(negedge clk);
    byte_valid = 1'b0;
    restart    = 1'b1;
    @(negedge clk);
    restart    = 1'b0;
    for (int i = 3; i < tx_q.size(); i++) send_byte(tx_q[i], 1'b0);
    wait_end();
    compare_results("restart_ignored");
    end_frame();

`ifdef LOADER_CHECKSUM_EN
    tx_q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h32};
    run_frame("chk_good", 1'b0);
    check("chk_good_done", 64'(load_done), 64'd1);
    end_frame();
    tx_q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h00};
    run_frame("chk_bad", 1'b0);
    check("chk_bad_err", 64'(load_error), 64'd1);
    end_frame();
`endif

    // Largest legal image, byte_valid held high throughout.
    build_frame(MAXW);
    run_frame("max_words", 1'b0);
    end_frame();

    // Random frames, including occasional oversize headers.
    for (int k = 0; k < 40; k++) begin
      int n;
      if ($urandom_range(0, 9) == 0) n = MAXW + 1 + int'($urandom_range(0, 100));
      else                           n = int'($urandom_range(0, 8));
      build_frame(n);
`ifdef LOADER_CHECKSUM_EN
      if (n <= MAXW && $urandom_range(0, 3) == 0) tx_q[tx_q.size()-1] = ~tx_q[tx_q.size()-1];
`endif
      run_frame("rand", 1'($urandom_range(0, 1)));
      end_frame();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
